// File: rtl/cpu_mem_arbiter.sv
// N-master arbiter serialising CPU bus requests onto one shared memory port.
// Define CPU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module cpu_mem_arbiter #(
    parameter int NMASTERS = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MEM_LAT  = 1
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [NMASTERS-1:0]        iReadEnable,
    input  logic [NMASTERS-1:0]        iWriteEnable,
    input  logic [NMASTERS*DATA_W/8-1:0] iByteEnable,
    input  logic [NMASTERS*DATA_W-1:0] iWriteData,
    input  logic [NMASTERS*ADDR_W-1:0] iAddress,
    output logic [DATA_W-1:0]          oReadData,
    output logic [NMASTERS-1:0]        oAck,
    output logic [NMASTERS-1:0]        oGrant,
    output logic                       oBusy,
    output logic                       MwReadEnable,
    output logic                       MwWriteEnable,
    output logic [DATA_W/8-1:0]        MwByteEnable,
    output logic [DATA_W-1:0]          MwWriteData,
    output logic [ADDR_W-1:0]          MwAddress,
    input  logic [DATA_W-1:0]          MwReadData
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t             state, state_nxt;
    logic [NMASTERS-1:0] req;
    logic               any_req;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   owner;
    logic               is_write;
    logic [CNT_W-1:0]   cnt;
    logic [NMASTERS-1:0] owner_oh;

    assign req     = iReadEnable | iWriteEnable;
    assign any_req = |req;

`ifdef CPU_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Descending scan so the candidate nearest to rr_ptr+1 is assigned last and wins.
    always_comb begin
        win_idx = '0;
        for (int i = NMASTERS; i >= 1; i--) begin
            if (req[(int'(rr_ptr) + i) % NMASTERS])
                win_idx = IDX_W'((int'(rr_ptr) + i) % NMASTERS);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            rr_ptr <= IDX_W'(NMASTERS - 1);
        else if (state == S_IDLE && any_req)
            rr_ptr <= win_idx;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NMASTERS - 1; i >= 0; i--) begin
            if (req[i])
                win_idx = IDX_W'(i);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = is_write ? S_ACK : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload is latched once in IDLE; a master dropping its request early is still served.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            owner        <= '0;
            is_write     <= 1'b0;
            cnt          <= '0;
            MwByteEnable <= '0;
            MwWriteData  <= '0;
            MwAddress    <= '0;
            oReadData    <= '0;
        end else begin
            case (state)
                S_IDLE: if (any_req) begin
                    owner        <= win_idx;
                    is_write     <= iWriteEnable[win_idx];
                    MwByteEnable <= iByteEnable[int'(win_idx)*BE_W +: BE_W];
                    MwWriteData  <= iWriteData[int'(win_idx)*DATA_W +: DATA_W];
                    MwAddress    <= iAddress[int'(win_idx)*ADDR_W +: ADDR_W];
                end
                S_ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
                S_WAIT: begin
                    if (cnt == '0)
                        oReadData <= MwReadData;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        oGrant          = '0;
        oAck            = '0;
        oBusy           = 1'b0;
        MwReadEnable    = 1'b0;
        MwWriteEnable   = 1'b0;
        if (state != S_IDLE) begin
            oGrant = owner_oh;
            oBusy  = 1'b1;
        end
        if (state == S_ACK)
            oAck = owner_oh;
        if (state == S_ISSUE) begin
            MwReadEnable  = ~is_write;
            MwWriteEnable = is_write;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter: three instances cover
// (2 masters, MEM_LAT=1), (2 masters, MEM_LAT=3) and (4 masters, MEM_LAT=2).
module tb_cpu_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Instance 0: NMASTERS=2, MEM_LAT=1
    logic        rst0;
    logic [1:0]  re0, we0, ack0, gnt0;
    logic [7:0]  be0;
    logic [63:0] wd0, ad0;
    logic [31:0] rd0, mwd0, ma0, mrd0;
    logic [3:0]  mbe0;
    logic        busy0, mre0, mwe0;

    cpu_mem_arbiter #(.NMASTERS(2), .DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_d0 (
        .iCLK(clk), .iRST(rst0), .iReadEnable(re0), .iWriteEnable(we0),
        .iByteEnable(be0), .iWriteData(wd0), .iAddress(ad0),
        .oReadData(rd0), .oAck(ack0), .oGrant(gnt0), .oBusy(busy0),
        .MwReadEnable(mre0), .MwWriteEnable(mwe0), .MwByteEnable(mbe0),
        .MwWriteData(mwd0), .MwAddress(ma0), .MwReadData(mrd0)
    );

    // Instance 1: NMASTERS=2, MEM_LAT=3
    logic        rst1;
    logic [1:0]  re1, we1, ack1, gnt1;
    logic [7:0]  be1;
    logic [63:0] wd1, ad1;
    logic [31:0] rd1, mwd1, ma1, mrd1;
    logic [3:0]  mbe1;
    logic        busy1, mre1, mwe1;

    cpu_mem_arbiter #(.NMASTERS(2), .DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_d1 (
        .iCLK(clk), .iRST(rst1), .iReadEnable(re1), .iWriteEnable(we1),
        .iByteEnable(be1), .iWriteData(wd1), .iAddress(ad1),
        .oReadData(rd1), .oAck(ack1), .oGrant(gnt1), .oBusy(busy1),
        .MwReadEnable(mre1), .MwWriteEnable(mwe1), .MwByteEnable(mbe1),
        .MwWriteData(mwd1), .MwAddress(ma1), .MwReadData(mrd1)
    );

    // Instance 2: NMASTERS=4, MEM_LAT=2
    logic         rst2;
    logic [3:0]   re2, we2, ack2, gnt2;
    logic [15:0]  be2;
    logic [127:0] wd2, ad2;
    logic [31:0]  rd2, mwd2, ma2, mrd2;
    logic [3:0]   mbe2;
    logic         busy2, mre2, mwe2;

    cpu_mem_arbiter #(.NMASTERS(4), .DATA_W(32), .ADDR_W(32), .MEM_LAT(2)) u_d2 (
        .iCLK(clk), .iRST(rst2), .iReadEnable(re2), .iWriteEnable(we2),
        .iByteEnable(be2), .iWriteData(wd2), .iAddress(ad2),
        .oReadData(rd2), .oAck(ack2), .oGrant(gnt2), .oBusy(busy2),
        .MwReadEnable(mre2), .MwWriteEnable(mwe2), .MwByteEnable(mbe2),
        .MwWriteData(mwd2), .MwAddress(ma2), .MwReadData(mrd2)
    );

`ifdef CPU_ARB_ROUND_ROBIN_EN
    logic [1:0] exp_cont [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] exp_quad [3] = '{4'b0010, 4'b1000, 4'b0010};
`else
    logic [1:0] exp_cont [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
    logic [3:0] exp_quad [3] = '{4'b0010, 4'b0010, 4'b0010};
`endif

    initial begin
        int got;
        int last_cyc;
        int lat;

        rst0 = 1'b1; re0 = '0; we0 = '0; be0 = '0; wd0 = '0; ad0 = '0; mrd0 = '0;
        rst1 = 1'b1; re1 = '0; we1 = '0; be1 = '0; wd1 = '0; ad1 = '0; mrd1 = '0;
        rst2 = 1'b1; re2 = '0; we2 = '0; be2 = '0; wd2 = '0; ad2 = '0; mrd2 = '0;
        tick;
        tick;

        // Reset values
        check("rst oAck",      64'(ack0),  64'h0);
        check("rst oGrant",    64'(gnt0),  64'h0);
        check("rst oBusy",     64'(busy0), 64'h0);
        check("rst MwRE",      64'(mre0),  64'h0);
        check("rst MwWE",      64'(mwe0),  64'h0);
        check("rst MwBE",      64'(mbe0),  64'h0);
        check("rst MwWD",      64'(mwd0),  64'h0);
        check("rst MwA",       64'(ma0),   64'h0);
        check("rst oReadData", 64'(rd0),   64'h0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        tick;
        check("idle busy", 64'(busy0), 64'h0);

        // Single read, master 1, MEM_LAT=1
        re0 = 2'b10; ad0[63:32] = 32'h100; mrd0 = 32'hDEADBEEF;
        tick;
        check("rd issue MwRE",  64'(mre0), 64'h1);
        check("rd issue MwWE",  64'(mwe0), 64'h0);
        check("rd issue MwA",   64'(ma0),  64'h100);
        check("rd issue grant", 64'(gnt0), 64'h2);
        check("rd issue busy",  64'(busy0), 64'h1);
        tick;
        check("rd wait MwRE", 64'(mre0), 64'h0);
        check("rd wait ack",  64'(ack0), 64'h0);
        tick;
        check("rd ack",       64'(ack0), 64'h2);
        check("rd data",      64'(rd0),  64'hDEADBEEF);
        check("rd ack grant", 64'(gnt0), 64'h2);
        re0 = '0;
        tick;
        check("rd done ack",  64'(ack0),  64'h0);
        check("rd done busy", 64'(busy0), 64'h0);
        check("rd hold data", 64'(rd0),   64'hDEADBEEF);

        // Single write, master 0
        we0 = 2'b01; ad0[31:0] = 32'h40; wd0[31:0] = 32'h12345678; be0[3:0] = 4'b0011;
        tick;
        check("wr issue MwWE", 64'(mwe0), 64'h1);
        check("wr issue MwRE", 64'(mre0), 64'h0);
        check("wr issue MwBE", 64'(mbe0), 64'h3);
        check("wr issue MwWD", 64'(mwd0), 64'h12345678);
        check("wr issue MwA",  64'(ma0),  64'h40);
        check("wr issue ack",  64'(ack0), 64'h0);
        tick;
        check("wr ack MwWE",  64'(mwe0), 64'h0);
        check("wr ack",       64'(ack0), 64'h1);
        check("wr hold MwA",  64'(ma0),  64'h40);
        we0 = '0;
        tick;
        check("wr done ack", 64'(ack0), 64'h0);

        // Read and write both set on master 1: write wins
        re0 = 2'b10; we0 = 2'b10; ad0[63:32] = 32'h200; wd0[63:32] = 32'hA5A5A5A5; be0[7:4] = 4'hF;
        tick;
        check("rw issue MwWE", 64'(mwe0), 64'h1);
        check("rw issue MwRE", 64'(mre0), 64'h0);
        check("rw issue MwWD", 64'(mwd0), 64'hA5A5A5A5);
        tick;
        check("rw ack",      64'(ack0), 64'h2);
        check("rw ack MwRE", 64'(mre0), 64'h0);
        re0 = '0; we0 = '0;
        tick;

        // Contention: both masters write continuously
        we0 = 2'b11; ad0 = {32'h2000, 32'h1000};
        got = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 40 && got < 4; cyc++) begin
            tick;
            if (ack0 != 2'b00) begin
                check($sformatf("cont ack %0d", got), 64'(ack0), 64'(exp_cont[got]));
                if (got > 0)
                    check($sformatf("cont spacing %0d", got), 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                got++;
            end
        end
        check("cont ack count", 64'(got), 64'd4);
        we0 = '0;
        tick;
        tick;

        // Reset during WAIT, MEM_LAT=3
        re1 = 2'b01; ad1[31:0] = 32'h80; mrd1 = 32'hCAFEF00D;
        tick;
        check("lat3 issue MwRE", 64'(mre1), 64'h1);
        tick;
        tick;
        check("lat3 wait ack", 64'(ack1), 64'h0);
        rst1 = 1'b1;
        tick;
        check("lat3 rst ack",   64'(ack1),  64'h0);
        check("lat3 rst grant", 64'(gnt1),  64'h0);
        check("lat3 rst busy",  64'(busy1), 64'h0);
        check("lat3 rst MwRE",  64'(mre1),  64'h0);
        check("lat3 rst MwA",   64'(ma1),   64'h0);
        check("lat3 rst data",  64'(rd1),   64'h0);
        rst1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (ack1 != 2'b00) begin
                lat = k;
                break;
            end
        end
        check("lat3 ack latency", 64'(lat),  64'd5);
        check("lat3 ack",         64'(ack1), 64'h1);
        check("lat3 data",        64'(rd1),  64'hCAFEF00D);
        re1 = '0;
        tick;

        // NMASTERS=4, MEM_LAT=2: master 0 granted first, then masters 1 and 3 contend
        we2 = 4'b0001; ad2[31:0] = 32'h4;
        tick;
        check("quad m0 issue", 64'(mwe2), 64'h1);
        tick;
        check("quad m0 ack", 64'(ack2), 64'h1);
        we2 = '0;
        tick;
        re2 = 4'b1010; ad2[63:32] = 32'h10; ad2[127:96] = 32'h30; mrd2 = 32'h55;
        got = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 60 && got < 3; cyc++) begin
            tick;
            if (ack2 != 4'b0000) begin
                check($sformatf("quad ack %0d", got), 64'(ack2), 64'(exp_quad[got]));
                if (got > 0)
                    check($sformatf("quad spacing %0d", got), 64'(cyc - last_cyc), 64'd5);
                last_cyc = cyc;
                got++;
            end
        end
        check("quad ack count", 64'(got), 64'd3);
        check("quad data",      64'(rd2), 64'h55);
        re2 = '0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
